// File: rtl/rpn_stack_ctrl.sv
// RPN token sequencer for an external stack: operands are pushed directly,
// operators pop two values, combine them and push the result back.
module rpn_stack_ctrl #(
  parameter int N     = 7,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tok_valid,
  input  logic       tok_is_op,
  input  logic [N:0] tok_data,
  output logic       tok_ready,
  input  logic       err_clr,
  output logic       stk_En,
  output logic       stk_PushPop,
  output logic [N:0] stk_IN,
  input  logic [N:0] stk_OUT,
  input  logic       stk_empty,
  input  logic       stk_full,
  input  logic [N:0] stk_counter,
  output logic [N:0] top_value,
  output logic       top_valid,
  output logic       busy,
  output logic       err_overflow,
  output logic       err_underflow
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_POP_B  = 2'd1;
  localparam logic [1:0] S_POP_A  = 2'd2;
  localparam logic [1:0] S_PUSH_R = 2'd3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  localparam logic [N:0] TWO_C = (N+1)'(2);

  function automatic logic [N:0] alu(input logic [1:0] op,
                                     input logic [N:0] a,
                                     input logic [N:0] b);
    logic [N:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [1:0] state_q, state_d;
  logic [N:0] opa_q, opa_d;
  logic [N:0] opb_q, opb_d;
  logic [1:0] opc_q, opc_d;
  logic       ovf_q, unf_q;

  logic       ready_s;
  logic       accept_s;
  logic       full_s;
  logic       ovf_set_s;
  logic       unf_set_s;
  logic       en_s;
  logic       pp_s;
  logic [N:0] in_s;

  // Occupancy also guards against a stack whose full flag lags its counter.
  assign full_s   = stk_full | ({{(31-N){1'b0}}, stk_counter} >= 32'(DEPTH));
  assign ready_s  = ~reset & (state_q == S_IDLE);
  assign accept_s = tok_valid & ready_s;

  // Next-state, operand capture and stack command decode.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opc_d     = opc_q;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    en_s      = 1'b0;
    pp_s      = 1'b0;
    in_s      = '0;
    case (state_q)
      S_IDLE: begin
        if (accept_s && !tok_is_op) begin
          if (!full_s) begin
            en_s = 1'b1;
            in_s = tok_data;
          end else begin
            ovf_set_s = 1'b1;
          end
        end else if (accept_s && tok_is_op) begin
          if (stk_counter >= TWO_C) begin
            opc_d   = tok_data[1:0];
            state_d = S_POP_B;
          end else begin
            unf_set_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP_B: begin
        opb_d   = stk_OUT;
        en_s    = 1'b1;
        pp_s    = 1'b1;
        state_d = S_POP_A;
      end
      S_POP_A: begin
        opa_d   = stk_OUT;
        en_s    = 1'b1;
        pp_s    = 1'b1;
        state_d = S_PUSH_R;
      end
      S_PUSH_R: begin
        en_s    = 1'b1;
        in_s    = alu(opc_q, opa_q, opb_q);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and sticky error registers; a new error beats err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= 2'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      ovf_q   <= ovf_set_s | (ovf_q & ~err_clr);
      unf_q   <= unf_set_s | (unf_q & ~err_clr);
    end
  end

  assign tok_ready     = ready_s;
  assign busy          = ~ready_s;
  assign stk_En        = en_s & ~reset;
  assign stk_PushPop   = pp_s;
  assign stk_IN        = in_s;
  assign top_value     = stk_OUT;
  assign top_valid     = ~stk_empty;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: behavioural stack attached to the DUT, queue-based
// RPN reference model, directed cases followed by random token traffic.
module tb_rpn_stack_ctrl;

  localparam int N     = 7;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tok_valid = 1'b0;
  logic       tok_is_op = 1'b0;
  logic [N:0] tok_data = '0;
  logic       err_clr = 1'b0;
  logic       tok_ready;
  logic       stk_En, stk_PushPop;
  logic [N:0] stk_IN, stk_OUT, stk_counter, top_value;
  logic       stk_empty, stk_full, top_valid, busy, err_overflow, err_underflow;

  always #5 clk = ~clk;

  rpn_stack_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .tok_valid(tok_valid), .tok_is_op(tok_is_op), .tok_data(tok_data),
    .tok_ready(tok_ready), .err_clr(err_clr),
    .stk_En(stk_En), .stk_PushPop(stk_PushPop), .stk_IN(stk_IN),
    .stk_OUT(stk_OUT), .stk_empty(stk_empty), .stk_full(stk_full),
    .stk_counter(stk_counter),
    .top_value(top_value), .top_valid(top_valid), .busy(busy),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  // Attached stack sharing the controller reset.
  logic [N:0] mem [0:DEPTH-1];
  logic [3:0] cnt;
  assign stk_OUT     = (cnt != 4'd0) ? mem[3'(cnt - 4'd1)] : '0;
  assign stk_empty   = (cnt == 4'd0);
  assign stk_full    = (cnt == 4'(DEPTH));
  assign stk_counter = {4'd0, cnt};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (stk_En && !stk_PushPop && cnt < 4'(DEPTH)) begin
      mem[3'(cnt)] <= stk_IN;
      cnt          <= cnt + 4'd1;
    end else if (stk_En && stk_PushPop && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  int n_vec  = 0;
  int n_fail = 0;
  int exp_stk[$];
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int calc(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) & 255;
      1:       return (a - b) & 255;
      2:       return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check_status();
    check("busy_idle", busy, 32'd0);
    check("err_overflow", err_overflow, 32'(exp_ovf));
    check("err_underflow", err_underflow, 32'(exp_unf));
    check("stk_counter", stk_counter, 32'(exp_stk.size()));
    check("top_valid", top_valid, 32'(exp_stk.size() != 0));
    if (exp_stk.size() != 0) check("top_value", top_value, 32'(exp_stk[$]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_tok_ready", tok_ready, 32'd0);
    check("rst_stk_En", stk_En, 32'd0);
    check("rst_busy", busy, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    exp_stk.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #1;
    check("rel_tok_ready", tok_ready, 32'd1);
    check_status();
  endtask

  // One token (or idle cycle when v=0) offered in IDLE, then the full operator sequence.
  task automatic step(input logic v, input logic op, input logic [N:0] d, input logic clr);
    logic push_ok, op_ok;
    int a, b, r;
    r = 0;
    @(negedge clk);
    tok_valid = v; tok_is_op = op; tok_data = d; err_clr = clr;
    #1;
    push_ok = v && !op && exp_stk.size() < DEPTH;
    op_ok   = v && op && exp_stk.size() >= 2;
    check("tok_ready", tok_ready, 32'd1);
    check("stk_En_idle", stk_En, 32'(push_ok));
    if (push_ok) begin
      check("stk_PushPop_push", stk_PushPop, 32'd0);
      check("stk_IN_push", stk_IN, 32'(d));
    end
    exp_ovf = (v && !op && exp_stk.size() >= DEPTH) | (exp_ovf & !clr);
    exp_unf = (v && op && exp_stk.size() < 2) | (exp_unf & !clr);
    if (push_ok) exp_stk.push_back(int'(d));
    if (op_ok) begin
      b = exp_stk.pop_back();
      a = exp_stk.pop_back();
      r = calc(int'(d[1:0]), a, b);
    end
    @(posedge clk);
    #1;
    tok_valid = 1'b0; err_clr = 1'b0;
    if (op_ok) begin
      for (int k = 0; k < 3; k++) begin
        check("busy_op", busy, 32'd1);
        check("tok_ready_op", tok_ready, 32'd0);
        check("stk_En_op", stk_En, 32'd1);
        check("stk_PushPop_op", stk_PushPop, 32'(k < 2));
        if (k == 2) check("stk_IN_result", stk_IN, 32'(r));
        @(posedge clk);
        #1;
      end
      exp_stk.push_back(r);
    end
    check_status();
  endtask

  initial begin
    do_reset();

    // 5 3 SUB -> 2
    step(1'b1, 1'b0, 8'd5, 1'b0);
    step(1'b1, 1'b0, 8'd3, 1'b0);
    step(1'b1, 1'b1, 8'd1, 1'b0);
    check("sub_top", top_value, 32'd2);

    // 200 100 ADD wraps to 44
    do_reset();
    step(1'b1, 1'b0, 8'd200, 1'b0);
    step(1'b1, 1'b0, 8'd100, 1'b0);
    step(1'b1, 1'b1, 8'd0, 1'b0);
    check("add_wrap", top_value, 32'd44);

    // underflow on a single operand
    do_reset();
    step(1'b1, 1'b0, 8'd7, 1'b0);
    step(1'b1, 1'b1, 8'd0, 1'b0);
    check("unf_flag", err_underflow, 32'd1);

    // fill, overflow, err_clr racing an overflow, then a plain clear
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'd10 + i[7:0]), 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    check("ovf_full", stk_full, 32'd1);
    check("ovf_top", top_value, 32'd17);
    step(1'b1, 1'b0, 8'h66, 1'b1);
    check("ovf_clr_race", err_overflow, 32'd1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    check("ovf_cleared", err_overflow, 32'd0);

    // reset landing in POP_A
    do_reset();
    step(1'b1, 1'b0, 8'd4, 1'b0);
    step(1'b1, 1'b0, 8'd9, 1'b0);
    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'd2;
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    check("popb_en", stk_En, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("popa_rst_en", stk_En, 32'd0);
    check("popa_rst_ready", tok_ready, 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_en", stk_En, 32'd0);
    check("rst_mid_cnt", stk_counter, 32'd0);
    check("rst_mid_ovf", err_overflow, 32'd0);
    check("rst_mid_unf", err_underflow, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_stk.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #1;
    check("rel_ready", tok_ready, 32'd1);
    check("rel_en", stk_En, 32'd0);
    @(posedge clk);
    #1;
    check_status();

    // random token traffic against the queue model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 2) == 0),
           8'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rpn_stack_ctrl.md
RPN_STACK_CTRL -- requirements
Module: rpn_stack_ctrl

Interface
REQ-001 Parameters SHALL be exactly two:
- N, default 7: data MSB index; data width is N+1.
- DEPTH, default 8: capacity of the attached stack.
REQ-002 Clock and reset SHALL be: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Reset SHALL be: reset  input  1  synchronous, active-high.
REQ-004 Token input signals SHALL be:
- tok_valid  input  1  token offered.
- tok_is_op  input  1  1 = operator token, 0 = operand token.
- tok_data  input  N+1  operand value, or opcode in bits [1:0].
- tok_ready  output  1  token accepted when tok_valid & tok_ready.
REQ-005 Error-clear input SHALL be: err_clr  input  1  clears sticky error flags.
REQ-006 Stack command outputs SHALL be:
- stk_En  output  1  stack operation enable.
- stk_PushPop  output  1  0 = push, 1 = pop.
- stk_IN  output  N+1  push data.
REQ-007 Stack status inputs SHALL be:
- stk_OUT  input  N+1  current top of stack.
- stk_empty  input  1  stack empty.
- stk_full  input  1  stack full.
- stk_counter  input  N+1  stack occupancy.
REQ-008 Status outputs SHALL be:
- top_value  output  N+1  equal to stk_OUT.
- top_valid  output  1  equal to ~stk_empty.
- busy  output  1  FSM not in IDLE.
- err_overflow  output  1  sticky overflow error.
- err_underflow  output  1  sticky underflow error.

Function
REQ-009 FSM states SHALL be IDLE, POP_B, POP_A, PUSH_R; tok_ready=1 only in IDLE, and busy = ~tok_ready.
REQ-010 When an operand is accepted in IDLE and stk_full=0, the block SHALL assert stk_En=1, stk_PushPop=0, stk_IN=tok_data in the same cycle (combinational) and remain in IDLE.
REQ-011 When an operand is accepted in IDLE and stk_full=1, the block SHALL drop the operand, keep stk_En=0, and set err_overflow on the next edge.
REQ-012 When an operator is accepted in IDLE and stk_counter>=2, the block SHALL latch tok_data[1:0] as opcode and go to POP_B.
REQ-013 When an operator is accepted in IDLE and stk_counter<2, the block SHALL drop the operator, keep stk_En=0, set err_underflow, and stay in IDLE.
REQ-014 In POP_B the block SHALL latch stk_OUT into opB, drive stk_En=1 and stk_PushPop=1, and go to POP_A.
REQ-015 In POP_A the block SHALL latch stk_OUT into opA, drive stk_En=1 and stk_PushPop=1, and go to PUSH_R.
REQ-016 In PUSH_R the block SHALL drive stk_En=1, stk_PushPop=0, stk_IN=result, and go to IDLE.
REQ-017 Opcodes SHALL be: 00 ADD opA+opB, 01 SUB opA-opB, 10 AND, 11 XOR; arithmetic wraps modulo 2^(N+1) and no carry or borrow is reported.
REQ-018 An operator SHALL take 3 cycles after acceptance (one pop, one pop, one push); the next token is accepted in the 4th cycle.
REQ-019 When tok_valid=0, or the FSM is not in IDLE, stk_En SHALL be 0 except in POP_B, POP_A and PUSH_R.
REQ-020 Operators SHALL never raise err_overflow, because their net occupancy change is -1.
REQ-021 Error flags SHALL be sticky; err_clr clears both flags on the next edge, and an error condition in the same cycle as err_clr SHALL win (flag set).
REQ-022 Error flags SHALL NOT block token acceptance.

Reset
REQ-023 While reset=1, the block SHALL hold tok_ready=0 and stk_En=0.
REQ-024 On an edge with reset=1, the block SHALL set state=IDLE, opA=opB=opcode=0, err_overflow=err_underflow=0.
REQ-025 A reset during POP_B, POP_A or PUSH_R SHALL abandon the operation with no further stack commands; tok_ready=1 on the first cycle after reset deasserts.
REQ-026 The attached stack SHALL share the same reset, so occupancy is 0 after reset.

Verification
REQ-027 Push 5, push 3, SUB -> top_value=2, stk_counter=1, busy high for exactly 3 cycles.
REQ-028 Push 200, push 100, ADD -> top_value=44 (wrap), no error flags set.
REQ-029 Push 7, ADD -> err_underflow=1, stk_counter=1, top_value=7, no pop issued.
REQ-030 Push 8 operands, 9th operand 0x55 -> err_overflow=1, stk_full=1, top_value=8th operand, stk_counter=8.
REQ-031 Reset asserted in POP_A -> next cycle state IDLE, errors 0, stk_En=0; after release tok_ready=1, stk_counter=0.
REQ-032 err_clr together with an overflowing push -> err_overflow stays 1; err_clr alone the next cycle -> 0.
